result_drain_ctrl: RTL

Sequences the four 16-bit results of a 2x2 matmul from the MMU's staggered result port onto the 8-bit host output bus. Results land in a two-bank buffer so the MMU can compute the next job while the previous one drains. Output is a valid/ready byte stream. The block reports to the control unit whether a new job may be started without overflowing the buffer.

---
 rtl/tpu_pkg.sv | 17 +
 rtl/result_drain_bank.sv | 28 ++
 rtl/result_drain_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// Shared constants and encodings for the MMU result drain path.
package tpu_pkg;
    localparam int N_RES         = 4;
    localparam int OUT_W         = 8;
    localparam int DATA_W        = 2 * OUT_W;
    localparam int ENT_W         = $clog2(N_RES);
    localparam int BYTES_PER_JOB = N_RES * DATA_W / OUT_W;
    localparam int IDX_W         = $clog2(BYTES_PER_JOB);

    // Within each result word, the high byte goes out first.
    localparam bit HI_FIRST = 1'b1;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_SEND = 1'b1
    } rd_state_e;
endpackage

// File: rtl/result_drain_bank.sv
// Two-bank result register file: one write port, combinational byte read mux.
module result_bank
    import tpu_pkg::*;
(
    input  logic              clk,
    input  logic              we_i,
    input  logic              wr_bank_i,
    input  logic [ENT_W-1:0]  wr_ent_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_bank_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [OUT_W-1:0]  rd_byte_o
);
    // Data array is left unreset; the full flags say which entries are live.
    logic [DATA_W-1:0] mem_q [2][N_RES];
    logic [DATA_W-1:0] rd_word;
    logic              sel_hi;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[wr_bank_i][wr_ent_i] <= wr_data_i;
    end

    always_comb begin
        rd_word   = mem_q[rd_bank_i][rd_idx_i[IDX_W-1:1]];
        sel_hi    = ((rd_idx_i[0] == 1'b0) == HI_FIRST);
        rd_byte_o = sel_hi ? rd_word[DATA_W-1 -: OUT_W] : rd_word[OUT_W-1:0];
    end
endmodule

// File: rtl/result_drain_ctrl.sv
// Double-buffered drain of 2x2 matmul results onto an 8-bit valid/ready stream;
// the MMU fills one bank while the host drains the other.
module result_drain_ctrl
    import tpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              can_accept,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_last,
    output logic              busy,
    output logic              overflow
);
    localparam logic [ENT_W-1:0] LAST_ENT = ENT_W'(N_RES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_JOB - 1);

    rd_state_e        state_q,    state_d;
    logic [1:0]       full_q,     full_d;
    logic             wr_bank_q,  wr_bank_d;
    logic [ENT_W-1:0] fill_cnt_q, fill_cnt_d;
    logic             rd_bank_q,  rd_bank_d;
    logic [IDX_W-1:0] rd_idx_q,   rd_idx_d;
    logic             overflow_q, overflow_d;

    logic             we;
    logic [OUT_W-1:0] rd_byte;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RD_IDLE;
            full_q     <= '0;
            wr_bank_q  <= 1'b0;
            fill_cnt_q <= '0;
            rd_bank_q  <= 1'b0;
            rd_idx_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            full_q     <= full_d;
            wr_bank_q  <= wr_bank_d;
            fill_cnt_q <= fill_cnt_d;
            rd_bank_q  <= rd_bank_d;
            rd_idx_q   <= rd_idx_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        full_d     = full_q;
        wr_bank_d  = wr_bank_q;
        fill_cnt_d = fill_cnt_q;
        rd_bank_d  = rd_bank_q;
        rd_idx_d   = rd_idx_q;
        overflow_d = overflow_q;
        we         = 1'b0;

        if (clear) begin
            // A result arriving alongside clear is dropped with the partial job.
            state_d    = RD_IDLE;
            full_d     = '0;
            wr_bank_d  = 1'b0;
            fill_cnt_d = '0;
            rd_bank_d  = 1'b0;
            rd_idx_d   = '0;
            overflow_d = 1'b0;
        end else begin
            if (res_valid) begin
                if (!full_q[wr_bank_q]) begin
                    we         = 1'b1;
                    fill_cnt_d = fill_cnt_q + 1'b1;
                    if (fill_cnt_q == LAST_ENT) begin
                        full_d[wr_bank_q] = 1'b1;
                        wr_bank_d         = ~wr_bank_q;
                    end
                end else begin
                    overflow_d = 1'b1;
                end
            end

            // Writer and reader never touch the same full bit in one cycle.
            unique case (state_q)
                RD_IDLE: if (full_q[rd_bank_q]) state_d = RD_SEND;
                RD_SEND: begin
                    if (out_ready) begin
                        rd_idx_d = rd_idx_q + 1'b1;
                        if (rd_idx_q == LAST_IDX) begin
                            full_d[rd_bank_q] = 1'b0;
                            rd_bank_d         = ~rd_bank_q;
                            state_d           = RD_IDLE;
                        end
                    end
                end
                default: state_d = RD_IDLE;
            endcase
        end
    end

    result_bank u_bank (
        .clk       (clk),
        .we_i      (we),
        .wr_bank_i (wr_bank_q),
        .wr_ent_i  (fill_cnt_q),
        .wr_data_i (res_data),
        .rd_bank_i (rd_bank_q),
        .rd_idx_i  (rd_idx_q),
        .rd_byte_o (rd_byte)
    );

    assign out_valid  = (state_q == RD_SEND);
    assign out_data   = out_valid ? rd_byte : '0;
    assign out_last   = out_valid && (rd_idx_q == LAST_IDX);
    assign can_accept = ~full_q[wr_bank_q];
    assign busy       = (|full_q) || (fill_cnt_q != '0);
    assign overflow   = overflow_q;
endmodule
